// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run-length event controller: controller states
// and the smallest run length the controller will track.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      TRACK = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int MIN_LEN = 2;

endpackage

// File: rtl/run_len_counter.sv
// Tracks the value and length of the current run of equal serial samples and
// flags the accepted sample that completes a run of the configured length.
module run_len_counter
   import run_ctrl_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             accept,
   input  logic             first,
   input  logic             s,
   input  logic [LEN_W-1:0] len,
   output logic             hit
);

   logic             last;
   logic [LEN_W-1:0] run_cnt;
   logic [LEN_W-1:0] next_cnt;

   // The first sample after arming always starts a fresh run, whatever last holds.
   always_comb begin
      next_cnt = (first || (s != last)) ? LEN_W'(1) : run_cnt + LEN_W'(1);
      hit      = accept && (next_cnt == len);
   end

   // A completed run restarts from zero so consecutive events never share samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last    <= 1'b0;
         run_cnt <= '0;
      end else if (clear) begin
         last    <= 1'b0;
         run_cnt <= '0;
      end else if (accept) begin
         if (hit) begin
            run_cnt <= '0;
         end else begin
            run_cnt <= next_cnt;
            last    <= s;
         end
      end
   end

endmodule

// File: rtl/run_event_ctrl.sv
// Run-length event controller: arms on start, watches a serial sample stream
// and raises a handshaked event each time a run of len equal samples completes.
module run_event_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             s_valid,
   input  logic             s,
   output logic             s_ready,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic             ev_bit,
   output logic [CNT_W-1:0] ev_count,
   output logic             busy
);

   state_t           state;
   logic [LEN_W-1:0] len;
   logic             arm;
   logic             accept;
   logic             hit;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
      return (v < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : v;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // stop wins over a coincident sample, so the aborted sample never forms an event.
   assign arm    = (state == IDLE) && start && !stop;
   assign accept = s_valid && s_ready && !stop;

   run_len_counter #(
      .LEN_W (LEN_W)
   ) u_run_len_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (arm),
      .accept (accept),
      .first  (state == ARMED),
      .s      (s),
      .len    (len),
      .hit    (hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         len      <= '0;
         s_ready  <= 1'b0;
         ev_valid <= 1'b0;
         ev_bit   <= 1'b0;
         ev_count <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  state    <= ARMED;
                  len      <= clamp_len(cfg_len);
                  ev_count <= '0;
                  s_ready  <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ARMED: begin
               if (stop) begin
                  state    <= IDLE;
                  s_ready  <= 1'b0;
                  ev_valid <= 1'b0;
                  busy     <= 1'b0;
               end else if (accept) begin
                  state <= TRACK;
               end
            end
            TRACK: begin
               if (stop) begin
                  state    <= IDLE;
                  s_ready  <= 1'b0;
                  ev_valid <= 1'b0;
                  busy     <= 1'b0;
               end else if (hit) begin
                  state    <= HOLD;
                  ev_valid <= 1'b1;
                  ev_bit   <= s;
                  ev_count <= sat_inc(ev_count);
                  s_ready  <= 1'b0;
               end
            end
            HOLD: begin
               // ev_count was already bumped on entry, so stop here loses nothing.
               if (stop) begin
                  state    <= IDLE;
                  s_ready  <= 1'b0;
                  ev_valid <= 1'b0;
                  busy     <= 1'b0;
               end else if (ev_ready) begin
                  state    <= TRACK;
                  ev_valid <= 1'b0;
                  s_ready  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_event_ctrl.sv
// Randomised scoreboard bench for run_event_ctrl: a queue-based run model
// predicts events, and a separate monitor checks each event as it is raised.
module tb_run_event_ctrl;

   localparam int LEN_W = 4;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             s_valid = 1'b0;
   logic             s = 1'b0;
   logic             ev_ready = 1'b0;
   logic             s_ready;
   logic             ev_valid;
   logic             ev_bit;
   logic [CNT_W-1:0] ev_count;
   logic             busy;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic b;
      int   c;
   } exp_t;

   exp_t sb_q[$];

   // Reference model: armed/holding flags, latched length, event count and
   // the samples making up the current run.
   bit m_active = 1'b0;
   bit m_hold   = 1'b0;
   int m_len    = 0;
   int m_cnt    = 0;
   bit run_q[$];

   run_event_ctrl #(
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .cfg_len  (cfg_len),
      .s_valid  (s_valid),
      .s        (s),
      .s_ready  (s_ready),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_bit   (ev_bit),
      .ev_count (ev_count),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: check outputs against the model, drive the inputs
   // for the coming rising edge, then advance the model across that edge.
   task automatic cycle(input logic st, input logic sp, input logic [LEN_W-1:0] cl,
                        input logic sv, input logic sb, input logic rdy);
      @(negedge clk);
      check("s_ready", s_ready, m_active && !m_hold);
      check("busy", busy, m_active);
      check("ev_valid", ev_valid, m_hold);
      check("ev_count", ev_count, m_cnt);
      start = st; stop = sp; cfg_len = cl; s_valid = sv; s = sb; ev_ready = rdy;
      if (!m_active) begin
         if (st && !sp) begin
            m_active = 1'b1;
            m_hold   = 1'b0;
            m_len    = (int'(cl) < 2) ? 2 : int'(cl);
            m_cnt    = 0;
            run_q.delete();
         end
      end else if (sp) begin
         m_active = 1'b0;
         m_hold   = 1'b0;
      end else if (m_hold) begin
         if (rdy) m_hold = 1'b0;
      end else if (sv) begin
         if (run_q.size() > 0 && run_q[$] != sb) run_q.delete();
         run_q.push_back(sb);
         if (run_q.size() == m_len) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            sb_q.push_back('{b: sb, c: m_cnt});
            run_q.delete();
            m_hold = 1'b1;
         end
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      start = 1'b0; stop = 1'b0; s_valid = 1'b0; ev_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_ev_valid", ev_valid, 0);
      check("rst_ev_bit", ev_bit, 0);
      check("rst_ev_count", ev_count, 0);
      m_active = 1'b0; m_hold = 1'b0; m_cnt = 0;
      run_q.delete();
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: on each newly raised event, pop the expectation and compare;
   // while the event is held, its bit and count must not move.
   initial begin
      logic prev;
      logic hb;
      int   hc;
      exp_t e;
      prev = 1'b0; hb = 1'b0; hc = 0;
      forever begin
         @(negedge clk);
         #2;
         if (ev_valid && !prev) begin
            if (sb_q.size() == 0) begin
               check("ev_unexpected", ev_valid, 0);
            end else begin
               e = sb_q.pop_front();
               check("ev_bit", ev_bit, e.b);
               check("ev_cnt_at_event", ev_count, e.c);
               hb = e.b;
               hc = e.c;
            end
         end else if (ev_valid) begin
            check("ev_bit_hold", ev_bit, hb);
            check("ev_cnt_hold", ev_count, hc);
         end
         prev = ev_valid;
      end
   end

   initial begin
      logic pat [4];
      pat = '{1'b1, 1'b0, 1'b1, 1'b0};
      #1;
      check("init_s_ready", s_ready, 0);
      check("init_busy", busy, 0);
      check("init_ev_valid", ev_valid, 0);
      check("init_ev_bit", ev_bit, 0);
      check("init_ev_count", ev_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // len 3, run of three 1s, then a held event ignoring samples
      cycle(1, 0, 3, 0, 0, 0);
      repeat (3) cycle(0, 0, 0, 1, 1, 0);
      repeat (5) cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);

      // back-to-back zeros with ev_ready high, then alternating bits
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 0, 3, 0, 0, 0);
      repeat (9) cycle(0, 0, 0, 1, 0, 1);
      foreach (pat[i]) cycle(0, 0, 0, 1, pat[i], 1);
      cycle(0, 0, 0, 0, 0, 1);

      // short configured lengths clamp to 2
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 0, 0);
      repeat (2) cycle(0, 0, 0, 1, 1, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      repeat (2) cycle(0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);

      // stop while an event is pending, count retained in IDLE
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 0, 2, 0, 0, 0);
      repeat (2) cycle(0, 0, 0, 1, 1, 0);
      cycle(0, 1, 0, 0, 0, 0);
      repeat (3) cycle(0, 0, 0, 1, 1, 1);

      // reset mid-run
      cycle(1, 0, 3, 0, 0, 0);
      repeat (2) cycle(0, 0, 0, 1, 1, 0);
      reset_pulse();
      cycle(0, 0, 0, 0, 0, 0);

      // count saturation
      cycle(1, 0, 2, 0, 0, 0);
      repeat (25) cycle(0, 0, 0, 1, 1, 1);
      cycle(0, 1, 0, 0, 0, 0);

      // random traffic, runs biased to stay long
      for (int i = 0; i < 800; i++) begin
         logic rs;
         rs = ($urandom_range(0, 3) == 0) ? ~s : s;
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 23) == 0),
               LEN_W'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0), rs,
               ($urandom_range(0, 1) == 1));
      end

      cycle(0, 1, 0, 0, 0, 1);
      repeat (4) cycle(0, 0, 0, 0, 0, 1);
      check("sb_drain", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/run_event_ctrl.md
RUN_EVENT_CTRL -- requirements
Module: run_event_ctrl

Interface
REQ-001 Parameter LEN_W, default 4: width of the run-length configuration.
REQ-002 Parameter CNT_W, default 8: width of the event counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low; one clock only.
REQ-005 start  input  1  arm request; acted on only in IDLE.
REQ-006 stop  input  1  abort request; acted on in any non-IDLE state.
REQ-007 cfg_len  input  LEN_W  required run length; latched on an accepted start.
REQ-008 s_valid  input  1  serial sample S is valid this cycle.
REQ-009 s  input  1  serial sample bit.
REQ-010 s_ready  output  1  controller accepts a sample this cycle.
REQ-011 ev_valid  output  1  run event pending.
REQ-012 ev_ready  input  1  consumer accepts the event.
REQ-013 ev_bit  output  1  value of the run that caused the pending event.
REQ-014 ev_count  output  CNT_W  number of events since last accepted start.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, ARMED, TRACK and HOLD.
REQ-017 A sample SHALL be accepted only when s_valid and s_ready are both high; s_ready SHALL be high in ARMED and TRACK only.
REQ-018 IDLE: start and not stop -> ARMED; latch len = max(cfg_len, 2); clear run_cnt and ev_count.
REQ-019 IDLE with start and stop both high SHALL remain IDLE; start outside IDLE SHALL be ignored.
REQ-020 ARMED: accepted sample -> TRACK; last = s; run_cnt = 1.
REQ-021 TRACK: when an accepted sample equals last, run_cnt increments; otherwise last = s and run_cnt = 1.
REQ-022 When run_cnt would reach len, the block SHALL do all of the following: set ev_bit = s; increment ev_count, saturating at all-ones; clear run_cnt to 0 while keeping last; go to HOLD.
REQ-023 Because of REQ-022, events SHALL NOT overlap: a run of 2*len equal samples yields exactly two events.
REQ-024 ev_valid SHALL be registered; it rises the cycle after the len-th sample is accepted.
REQ-025 HOLD: ev_valid high and ev_bit stable until ev_valid and ev_ready are both high; then -> TRACK and ev_valid low next cycle.
REQ-026 HOLD: no samples are accepted (s_ready low).
REQ-027 stop in ARMED, TRACK or HOLD SHALL go to IDLE next cycle and drop ev_valid.
REQ-028 If stop and ev_ready coincide in HOLD, the handshake counts as completed; ev_count is already updated.
REQ-029 ev_count SHALL hold its value in IDLE until the next accepted start.
REQ-030 Arithmetic: run_cnt is LEN_W bits and never exceeds len; the len comparison is unsigned.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE; ev_valid, ev_bit, s_ready and busy to 0; ev_count, run_cnt, last and len to 0.
REQ-032 Reset asserted mid-run or mid-handshake SHALL discard the pending event without any handshake.

Structure
REQ-033 A shared package run_ctrl_pkg SHALL hold the state enumeration and the constant MIN_LEN = 2.
REQ-034 One sub-module, run_len_counter, SHALL hold last, run_cnt and the len-reached compare; the FSM, handshake and ev_count stay in run_event_ctrl.

Verification
REQ-035 cfg_len=3, start; samples 1,1,1 accepted back-to-back -> ev_valid high one cycle after the third sample; ev_bit=1; ev_count=1.
REQ-036 cfg_len=3; samples 0,0,0,0,0,0 with ev_ready tied high -> two events, ev_bit=0, ev_count=2; samples 1,0,1,0 -> no event.
REQ-037 cfg_len=0 or 1 -> behaves as len 2: samples 1,1 -> one event.
REQ-038 Event pending, ev_ready held low 5 cycles -> ev_valid and ev_bit stable, s_ready low, s_valid samples ignored; ev_ready high -> TRACK next cycle.
REQ-039 stop in HOLD -> IDLE next cycle, ev_valid low, ev_count retained; rst_n pulse mid-TRACK -> all outputs 0 asynchronously.
REQ-040 CNT_W=2; seven events -> ev_count saturates at 3.
